// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clock rate and the
// baud divider used by both the receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus a delay flop for
// falling-edge detection. All flops reset to the idle-high line level.
module uart_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_s1;
    logic rx_s2;
    logic rx_d;

    // NOTE: non-blocking assignments let each flop capture the previous stage's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_s = rx_s2;
    assign fall = rx_d & ~rx_s2;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: samples each bit at its centre using a baud counter and
// presents the byte on a held bus with a one-cycle done or framing-error strobe.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned BIT_CNT  = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CNT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    logic rx_s;
    logic fall;

    uart_bit_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    uart_state_t      state,     state_nxt;
    logic [CNT_W-1:0] cnt,       cnt_nxt;
    logic [2:0]       bit_idx,   bit_idx_nxt;
    logic [7:0]       sh,        sh_nxt;
    logic [7:0]       data_nxt;
    logic             done_nxt;
    logic             err_nxt;

    // NOTE: sh is an ordinary register, so it is reset with everything else; only RAM arrays are left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            sh        <= sh_nxt;
            rx_data   <= data_nxt;
            rx_done   <= done_nxt;
            frame_err <= err_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        sh_nxt      = sh;
        data_nxt    = rx_data;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                // A start bit that is high again at its centre was only a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rx_s, sh[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to re-arm for a back-to-back frame.
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        data_nxt = sh;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at BIT_CNT=10: table-driven frames with a
// byte scoreboard, plus back-to-back, glitch and mid-frame reset sequences.
module tb_uart_byte_rx;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 5_000_000;
    localparam int          BIT      = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    int err_pending     = 0;
    int done_cnt        = 0;
    int err_cnt         = 0;
    int last_done_cycle = -1;
    int prev_done_cycle = -1;
    bit prev_done       = 1'b0;
    bit prev_err        = 1'b0;
    bit prev_busy       = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done || frame_err) begin
                check("strobe_exclusive", int'(rx_done & frame_err), 0);
            end
            if (rx_done) begin
                done_cnt++;
                prev_done_cycle = last_done_cycle;
                last_done_cycle = cycle;
                check("busy_low_at_done", int'(busy), 0);
                check("busy_high_before_done", int'(prev_busy), 1);
                check("done_width", int'(prev_done), 0);
                check("done_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("done_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                err_cnt++;
                check("err_expected", int'(err_pending > 0), 1);
                check("err_width", int'(prev_err), 0);
                if (err_pending > 0) err_pending--;
            end
        end
        prev_done = rx_done;
        prev_err  = frame_err;
        prev_busy = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, output int t0);
        t0 = cycle;
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BIT);
        end
        rx = stop_v;
        tick(BIT);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0;
        int t1;
        int d0;
        int e0;
        int cnt_b;

        vecs[0] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h99, 1'b0, 0, 1, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};

        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        rst = 1'b0;
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_done", int'(rx_done), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);

        cnt_b = 0;
        repeat (200) begin
            @(negedge clk);
            if (rx_data != 8'h00 || rx_done || frame_err || busy) cnt_b++;
        end
        tick(1);
        check("idle_quiet", cnt_b, 0);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            if (vecs[i].exp_done != 0) exp_q.push_back(vecs[i].data);
            if (vecs[i].exp_err != 0) err_pending++;
            send_frame(vecs[i].data, vecs[i].stop, t0);
            if (!vecs[i].stop) begin
                cnt_b = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (busy) cnt_b++;
                end
                tick(1);
                check($sformatf("vec%0d_no_start_while_low", i), cnt_b, 0);
            end
            rx = 1'b1;
            tick(20);
            check($sformatf("vec%0d_done_count", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_err_count", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
            if (i == 0) check("latency_first_frame", last_done_cycle - t0, 98);
        end

        // Back-to-back frames with no idle gap.
        d0 = done_cnt;
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'hC4);
        send_frame(8'h3F, 1'b1, t0);
        send_frame(8'hC4, 1'b1, t1);
        tick(20);
        check("b2b_done_count", done_cnt - d0, 2);
        check("b2b_gap", last_done_cycle - prev_done_cycle, 100);
        check("b2b_rx_data", int'(rx_data), 8'hC4);

        // Short low glitch on an idle line.
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        cnt_b = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) cnt_b++;
        end
        tick(1);
        check("glitch_busy_cycles", cnt_b, 5);
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_no_err", err_cnt - e0, 0);
        check("glitch_rx_data", int'(rx_data), 8'hC4);

        // Reset in the middle of the data bits of 0xA5, then a clean 0x17.
        d0 = done_cnt;
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'hA5 >> i) & 8'h01) != 0;
            tick(BIT);
        end
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midreset_rx_data", int'(rx_data), 0);
        check("midreset_busy", int'(busy), 0);
        tick(30);
        check("midreset_no_done", done_cnt - d0, 0);
        exp_q.push_back(8'h17);
        send_frame(8'h17, 1'b1, t0);
        tick(20);
        check("after_reset_done_count", done_cnt - d0, 1);
        check("after_reset_rx_data", int'(rx_data), 8'h17);

        check("scoreboard_drained", exp_q.size(), 0);
        check("err_drained", err_pending, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
